// File: rtl/square_dac_spi.sv
// square_dac_spi: samples the square-wave Pulse each update tick and ships a 16-bit frame to a 12-bit SPI DAC
// Ports:
//   sysclk, reset_n       clock, synchronous active-low reset
//   Pulse, Enable_SW_2    generator outputs, synchronised here
//   amp_hi, amp_lo        DAC codes for Pulse high/low
//   dac_cs_n/sclk/mosi    SPI pins (mode 0, MSB first)
//   busy, frame_done      FSM active, one-cycle end-of-frame pulse
//   overrun               sticky: a tick arrived while a frame was in progress
module square_dac_spi #(
  parameter int         SAMPLE_DIV = 100,
  parameter int         SCLK_DIV   = 2,
  parameter logic [3:0] DAC_CMD    = 4'h3,
  parameter logic [11:0] IDLE_CODE = 12'h800
) (
  input  logic        sysclk,
  input  logic        reset_n,
  input  logic        Pulse,
  input  logic        Enable_SW_2,
  input  logic [11:0] amp_hi,
  input  logic [11:0] amp_lo,
  output logic        dac_cs_n,
  output logic        dac_sclk,
  output logic        dac_mosi,
  output logic        busy,
  output logic        frame_done,
  output logic        overrun
);
  localparam int CW = $clog2(SAMPLE_DIV + 1);
  localparam int DW = $clog2(SCLK_DIV + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(SAMPLE_DIV - 1);
  localparam logic [DW-1:0] DIV_MAX = DW'(SCLK_DIV - 1);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, HOLD} state_t;
  state_t st_q, st_d;
  logic [1:0] p_sync_q, e_sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] dv_q, dv_d;
  logic [3:0] bc_q, bc_d;
  // Bit 15 goes straight to mosi at LOAD, so only the remaining 15 bits are held.
  logic [14:0] sr_q, sr_d;
  logic sclk_q, sclk_d, cs_n_q, cs_n_d, mosi_q, mosi_d, done_q, done_d, ovr_q, ovr_d;
  logic tick;
  logic [15:0] word;
  assign tick = cnt_q == CNT_MAX;
  assign word = {DAC_CMD, !e_sync_q[1] ? IDLE_CODE : p_sync_q[1] ? amp_hi : amp_lo};
  always_comb begin
    st_d   = st_q;
    sr_d   = sr_q;
    dv_d   = dv_q;
    bc_d   = bc_q;
    sclk_d = sclk_q;
    cs_n_d = cs_n_q;
    mosi_d = mosi_q;
    done_d = 1'b0;
    ovr_d  = ovr_q | (tick & (st_q != IDLE));
    cnt_d  = tick ? '0 : cnt_q + CW'(1);
    case (st_q)
      IDLE: if (tick) begin
        st_d   = LOAD;
        sr_d   = word[14:0];
        cs_n_d = 1'b0;
        mosi_d = word[15];
      end
      LOAD: begin
        st_d = SHIFT;
        dv_d = '0;
        bc_d = '0;
      end
      SHIFT: begin
        dv_d = dv_q + DW'(1);
        if (dv_q == DIV_MAX) begin
          dv_d   = '0;
          sclk_d = ~sclk_q;
          // Falling edge: advance data, or close the frame after the 16th bit.
          if (sclk_q) begin
            if (bc_q == 4'd15) begin
              st_d   = HOLD;
              cs_n_d = 1'b1;
              mosi_d = 1'b0;
            end else begin
              bc_d   = bc_q + 4'd1;
              mosi_d = sr_q[14];
              sr_d   = {sr_q[13:0], 1'b0};
            end
          end
        end
      end
      HOLD: begin
        dv_d = dv_q + DW'(1);
        if (dv_q == DIV_MAX) begin
          st_d   = IDLE;
          dv_d   = '0;
          done_d = 1'b1;
        end
      end
      default: st_d = IDLE;
    endcase
  end
  always_ff @(posedge sysclk) begin
    if (!reset_n) begin
      st_q     <= IDLE;
      p_sync_q <= '0;
      e_sync_q <= '0;
      cnt_q    <= '0;
      dv_q     <= '0;
      bc_q     <= '0;
      sr_q     <= '0;
      sclk_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      mosi_q   <= 1'b0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      st_q     <= st_d;
      p_sync_q <= {p_sync_q[0], Pulse};
      e_sync_q <= {e_sync_q[0], Enable_SW_2};
      cnt_q    <= cnt_d;
      dv_q     <= dv_d;
      bc_q     <= bc_d;
      sr_q     <= sr_d;
      sclk_q   <= sclk_d;
      cs_n_q   <= cs_n_d;
      mosi_q   <= mosi_d;
      done_q   <= done_d;
      ovr_q    <= ovr_d;
    end
  end
  assign dac_cs_n   = cs_n_q;
  assign dac_sclk   = sclk_q;
  assign dac_mosi   = mosi_q;
  assign busy       = st_q != IDLE;
  assign frame_done = done_q;
  assign overrun    = ovr_q;
endmodule
